// File: rtl/mux_arb_pkg.sv
// Shared types and default sizing for the round-robin read arbiter.
package mux_arb_pkg;

  localparam int unsigned N_DEFAULT       = 4;
  localparam int unsigned ADDRESS_DEFAULT = 12;
  localparam int unsigned REQ_DEFAULT     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    RSP  = 2'd2
  } state_t;

endpackage

// File: rtl/mux4096to1_n.sv
// 4096-to-1 word selector over a flat storage array.
module mux4096to1_n #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] data [4096],
  input  logic [11:0]  sel,
  output logic [N-1:0] y
);

  assign y = data[sel];

endmodule

// File: rtl/mux_read_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid request at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned REQ = 4,
  parameter int unsigned IDW = (REQ > 1) ? $clog2(REQ) : 1
) (
  input  logic [REQ-1:0] req,
  input  logic [IDW-1:0] ptr,
  output logic [REQ-1:0] grant,
  output logic [IDW-1:0] idx,
  output logic           any
);

  // Explicit wrap so non-power-of-two REQ never aliases past the last requester.
  function automatic logic [IDW-1:0] wrap_idx(input int unsigned v);
    return (v >= REQ) ? IDW'(v - REQ) : IDW'(v);
  endfunction

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int unsigned i = 0; i < REQ; i++) begin
      if (!any && req[wrap_idx(32'(ptr) + i)]) begin
        any = 1'b1;
        idx = wrap_idx(32'(ptr) + i);
      end
    end
    grant[idx] = any;
  end

endmodule

// File: rtl/mux_read_arbiter.sv
// Shares one wide read mux among REQ requesters: grant, register select,
// capture the word a cycle later, return it on a tagged valid/ready channel.
module mux_read_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned N       = N_DEFAULT,
  parameter int unsigned ADDRESS = ADDRESS_DEFAULT,
  parameter int unsigned REQ     = REQ_DEFAULT,
  parameter int unsigned IDW     = (REQ > 1) ? $clog2(REQ) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [N-1:0]       data_i [2**ADDRESS],
  input  logic [REQ-1:0]     req_valid_i,
  input  logic [ADDRESS-1:0] req_addr_i [REQ],
  output logic [REQ-1:0]     req_ready_o,
  output logic               rsp_valid_o,
  output logic [IDW-1:0]     rsp_id_o,
  output logic [N-1:0]       rsp_data_o,
  input  logic               rsp_ready_i,
  output logic               busy_o
);

  state_t             state_q, state_d;
  logic [IDW-1:0]     ptr_q;
  logic [ADDRESS-1:0] sel_q;
  logic [IDW-1:0]     id_q;
  logic [N-1:0]       data_q;

  logic [REQ-1:0]     pick_grant;
  logic [IDW-1:0]     win;
  logic               pick_any;
  logic               grant_en;
  logic [IDW-1:0]     ptr_next;
  logic [N-1:0]       mux_y;

  rr_pick #(
    .REQ (REQ),
    .IDW (IDW)
  ) u_pick (
    .req   (req_valid_i),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (win),
    .any   (pick_any)
  );

  mux4096to1_n #(
    .N (N)
  ) u_mux (
    .data (data_i),
    .sel  (sel_q),
    .y    (mux_y)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Grants happen from IDLE, or back-to-back from RSP once the response is taken.
  always_comb begin
    state_d  = state_q;
    grant_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_en = 1'b1;
          state_d  = SEL;
        end
      end
      SEL: state_d = RSP;
      RSP: begin
        if (rsp_ready_i) begin
          if (pick_any) begin
            grant_en = 1'b1;
            state_d  = SEL;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ptr_next = (win == IDW'(REQ - 1)) ? '0 : win + IDW'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q  <= '0;
      sel_q  <= '0;
      id_q   <= '0;
      data_q <= '0;
    end else begin
      if (grant_en) begin
        sel_q <= req_addr_i[win];
        id_q  <= win;
        ptr_q <= ptr_next;
      end
      if (state_q == SEL) data_q <= mux_y;
    end
  end

  assign req_ready_o = grant_en ? pick_grant : '0;
  assign rsp_valid_o = (state_q == RSP);
  assign rsp_id_o    = id_q;
  assign rsp_data_o  = data_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_mux_read_arbiter.sv
// Directed, table-driven checks of grant order, latency, backpressure and reset.
module tb_mux_read_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  mem [4096];
  logic [3:0]  rv;
  logic [11:0] addr [4];
  logic [3:0]  ready;
  logic        valid;
  logic [1:0]  id;
  logic [3:0]  rdata;
  logic        rr;
  logic        busy;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic [3:0] rv;
    logic       rr;
    logic [3:0] ready;
    logic       valid;
    logic [1:0] id;
    logic [3:0] data;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  mux_read_arbiter dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .data_i      (mem),
    .req_valid_i (rv),
    .req_addr_i  (addr),
    .req_ready_o (ready),
    .rsp_valid_o (valid),
    .rsp_id_o    (id),
    .rsp_data_o  (rdata),
    .rsp_ready_i (rr),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h @%0t", name, got, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] v, input logic r, input logic [3:0] g,
                              input logic ov, input logic [1:0] oi, input logic [3:0] od,
                              input logic ob);
    vec_t t;
    t.rv = v; t.rr = r; t.ready = g; t.valid = ov; t.id = oi; t.data = od; t.busy = ob;
    return t;
  endfunction

  task automatic drive(input logic [3:0] v, input logic r);
    @(posedge clk);
    #1;
    rv = v;
    rr = r;
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    rv    = '0;
    rr    = 1'b1;
    for (int k = 0; k < 4096; k++) mem[k] = 4'(k);
    mem[12'h0A5] = 4'hC;
    mem[12'hFFF] = 4'h3;
    addr[0] = 12'h0A5;
    addr[1] = 12'h011;
    addr[2] = 12'h022;
    addr[3] = 12'hFFF;

    // all four requesting from ptr = 0
    tbl.push_back(mk(4'b1111, 1, 4'b0001, 0, 0, 0, 0));
    tbl.push_back(mk(4'b1111, 1, 4'b0000, 0, 0, 0, 1));
    tbl.push_back(mk(4'b1111, 1, 4'b0010, 1, 0, 4'hC, 1));
    tbl.push_back(mk(4'b1111, 1, 4'b0000, 0, 0, 0, 1));
    tbl.push_back(mk(4'b1111, 1, 4'b0100, 1, 1, 4'h1, 1));
    tbl.push_back(mk(4'b1111, 1, 4'b0000, 0, 0, 0, 1));
    tbl.push_back(mk(4'b1111, 1, 4'b1000, 1, 2, 4'h2, 1));
    tbl.push_back(mk(4'b1111, 1, 4'b0000, 0, 0, 0, 1));
    tbl.push_back(mk(4'b1111, 1, 4'b0001, 1, 3, 4'h3, 1));
    tbl.push_back(mk(4'b0000, 1, 4'b0000, 0, 0, 0, 1));
    tbl.push_back(mk(4'b0000, 1, 4'b0000, 1, 0, 4'hC, 1));
    tbl.push_back(mk(4'b0000, 1, 4'b0000, 0, 0, 0, 0));
    // move ptr to 2, then sparse 1010 under backpressure
    tbl.push_back(mk(4'b0010, 1, 4'b0010, 0, 0, 0, 0));
    tbl.push_back(mk(4'b1010, 1, 4'b0000, 0, 0, 0, 1));
    for (int k = 0; k < 5; k++) tbl.push_back(mk(4'b1010, 0, 4'b0000, 1, 1, 4'h1, 1));
    tbl.push_back(mk(4'b1010, 1, 4'b1000, 1, 1, 4'h1, 1));
    tbl.push_back(mk(4'b1010, 1, 4'b0000, 0, 0, 0, 1));
    tbl.push_back(mk(4'b1010, 1, 4'b0010, 1, 3, 4'h3, 1));
    tbl.push_back(mk(4'b0000, 1, 4'b0000, 0, 0, 0, 1));
    tbl.push_back(mk(4'b0000, 1, 4'b0000, 1, 1, 4'h1, 1));
    tbl.push_back(mk(4'b0000, 1, 4'b0000, 0, 0, 0, 0));
    // single request, ptr = 2 wraps to requester 0
    tbl.push_back(mk(4'b0001, 1, 4'b0001, 0, 0, 0, 0));
    tbl.push_back(mk(4'b0000, 1, 4'b0000, 0, 0, 0, 1));
    tbl.push_back(mk(4'b0000, 1, 4'b0000, 1, 0, 4'hC, 1));
    tbl.push_back(mk(4'b0000, 1, 4'b0000, 0, 0, 0, 0));

    #12;
    check("reset_ready", 32'(ready), 0);
    check("reset_valid", 32'(valid), 0);
    check("reset_busy",  32'(busy), 0);
    check("reset_id",    32'(id), 0);
    check("reset_data",  32'(rdata), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rv, tbl[i].rr);
      check($sformatf("v%0d_ready", i), 32'(ready), 32'(tbl[i].ready));
      check($sformatf("v%0d_valid", i), 32'(valid), 32'(tbl[i].valid));
      check($sformatf("v%0d_busy", i),  32'(busy),  32'(tbl[i].busy));
      if (tbl[i].valid) begin
        check($sformatf("v%0d_id", i),   32'(id),    32'(tbl[i].id));
        check($sformatf("v%0d_data", i), 32'(rdata), 32'(tbl[i].data));
      end
    end

    // array changes after capture must not alter the pending response (ptr = 1 here)
    drive(4'b1000, 1'b0);
    check("arr_grant", 32'(ready), 32'(4'b1000));
    drive(4'b0000, 1'b0);
    check("arr_sel_valid", 32'(valid), 0);
    @(posedge clk);
    #1;
    mem[12'hFFF] = 4'h9;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("arr_valid", 32'(valid), 1);
      check("arr_id",    32'(id), 3);
      check("arr_data",  32'(rdata), 32'(4'h3));
      @(negedge clk);
    end
    rr = 1'b1;
    #1;
    check("arr_release_data", 32'(rdata), 32'(4'h3));
    drive(4'b0000, 1'b1);
    check("arr_idle_valid", 32'(valid), 0);

    // reset in SEL: grant requester 0 so ptr becomes 1, then reset
    drive(4'b0001, 1'b1);
    check("rst_pre_grant", 32'(ready), 32'(4'b0001));
    @(posedge clk);
    #1;
    rv = 4'b0000;
    check("rst_in_sel_busy", 32'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(valid), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_ready", 32'(ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rst_no_rsp", 32'(valid), 0);
    end
    drive(4'b1111, 1'b1);
    check("rst_ptr_zero_grant", 32'(ready), 32'(4'b0001));
    drive(4'b0000, 1'b1);
    drive(4'b0000, 1'b1);
    check("rst_after_valid", 32'(valid), 1);
    check("rst_after_id",    32'(id), 0);
    check("rst_after_data",  32'(rdata), 32'(4'hC));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_read_arbiter.md
# mux_read_arbiter

Round-robin arbiter and sequencer that shares one wide read path (a 4096-entry, n-bit selection tree) among REQ requesters. It accepts one address per grant and registers the select. It captures the selected word one cycle later and returns it on a single valid/ready response channel tagged with the requester index. It sits between several consumers (fetch, load, debug) and one 4096-word storage array exposed as a flat `data_i` array.

## Interface
- N, 4, data word width
- ADDRESS, 12, select width; array depth is 2**ADDRESS
- REQ, 4, number of requesters (2..8)
- IDW, $clog2(REQ), response id width
- clk_i  in  1  clock, all state updates on rising edge
- rst_ni  in  1  reset; one clock; reset is asynchronous and active-low
- data_i  in  N x 2**ADDRESS  storage contents, entry k at data_i[k]
- req_valid_i  in  REQ  per-requester request valid
- req_addr_i  in  REQ x ADDRESS  per-requester address
- req_ready_o  out  REQ  one-hot grant; a request is accepted when req_valid_i[r] and req_ready_o[r] are both high
- rsp_valid_o  out  1  response valid
- rsp_id_o  out  IDW  index of the requester owning the response
- rsp_data_o  out  N  read word
- rsp_ready_i  in  1  response consumer ready
- busy_o  out  1  high in SEL or RSP

## Operation
- FSM states: IDLE, SEL, RSP. Reset state is IDLE.
- IDLE:
  - If any req_valid_i is high, grant the winner w: req_ready_o = one-hot(w).
  - Latch sel_q <= req_addr_i[w] and id_q <= w; set ptr <= (w+1) mod REQ; go to SEL.
  - Otherwise stay in IDLE.
- SEL:
  - The mux output for sel_q settles.
  - At the edge, data_q <= data_i[sel_q]; go to RSP.
  - req_ready_o = 0.
- RSP:
  - rsp_valid_o = 1; rsp_id_o = id_q; rsp_data_o = data_q.
  - If rsp_ready_i = 0: hold all outputs stable; req_ready_o = 0.
  - If rsp_ready_i = 1 and any req_valid_i: grant the new winner in the same cycle (back-to-back) and go to SEL.
  - If rsp_ready_i = 1 and no request: go to IDLE.
- Round-robin winner: the first r in the order ptr, ptr+1, … REQ-1, 0, … with req_valid_i[r] = 1. Ties cannot occur. ptr updates only on a grant.
- req_ready_o is purely combinational from state, ptr, req_valid_i and rsp_ready_i. It never depends on req_addr_i.
- data_i is sampled only at the SEL→RSP edge. Later changes to the array do not alter a pending response.
- A requester that drops valid before being granted is simply skipped. There is no retained request state.
- Out-of-range ptr values cannot occur (ptr < REQ by construction). When REQ is not a power of two, the wrap is explicit, not by truncation.

## Timing
- Reset values: state = IDLE, ptr = 0, sel_q = 0, id_q = 0, data_q = 0, rsp_valid_o = 0, req_ready_o = 0, busy_o = 0.
- Latency: grant in cycle t gives rsp_valid_o high in cycle t+2.
- Throughput: 1 response per 2 cycles with rsp_ready_i held high.
- rsp_valid_o stays high with stable id and data until the response handshake. It never drops without a handshake.
- Reset asserted mid-operation clears the pending response. No response is emitted after reset deasserts.
- Long combinational path: the data_i mux ends in data_q. sel_q is a register, so the mux path starts at a flop.

## Structure
- Package mux_arb_pkg holds the state enum (IDLE, SEL, RSP) and the default REQ/ADDRESS constants.
- Sub-module rr_pick: combinational round-robin picker. Inputs are the request vector and ptr; outputs are a one-hot grant, the winner index and an any flag.
- The datapath instantiates the library mux4096to1_n#(N) with sel_q as its select.

## Test plan
- Single request: req_valid_i = 0001, addr 0x0A5, data_i[0x0A5] = 4'hC. Expect req_ready_o = 0001 at t, then rsp_valid_o at t+2 with id 0 and data C.
- All four requesting continuously, rsp_ready_i = 1, ptr = 0 after reset. Expect grants 0,1,2,3,0 on alternating cycles and responses in the same order with the matching data.
- Backpressure: rsp_ready_i = 0 for 5 cycles during RSP. Expect outputs stable, req_ready_o = 0, no new grant; grant happens in the cycle ready rises.
- Array change after capture: write data_i[0xFFF] from 3 to 9 during RSP. Expect rsp_data_o = 3.
- Sparse requests 1010 with ptr = 2. Expect grant to requester 3 and ptr = 0; next grant to requester 1.
- Reset asserted in SEL. Expect state IDLE, rsp_valid_o = 0 and ptr = 0 immediately; no response after release.
